// File: rtl/cpu_io_bridge_if.sv
// Peripheral side of the CPU I/O bridge: request/ack handshake plus data paths.
interface cpu_io_bridge_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]   io_req;
  logic                io_wr;
  logic [7:0]          io_addr;
  logic [7:0]          io_data_in;
  logic [NUM_CH*8-1:0] io_data_out;
  logic [NUM_CH-1:0]   io_ack;

  modport master (
    output io_req, io_wr, io_addr, io_data_in,
    input  io_data_out, io_ack
  );

  modport slave (
    input  io_req, io_wr, io_addr, io_data_in,
    output io_data_out, io_ack
  );
endinterface

// File: rtl/cpu_io_bridge.sv
// Z80 I/O-bus bridge: synchronises the asynchronous port strobes, decodes the
// address against per-channel windows and issues one request per CPU access.
// Reads may stall the CPU on wait_n until the selected channel acknowledges.
module cpu_io_bridge #(
  parameter int                  NUM_CH      = 2,
  parameter logic [NUM_CH*8-1:0] CH_BASE     = {8'h30, 8'h98},
  parameter logic [NUM_CH*8-1:0] CH_MASK     = {8'hFC, 8'hFC},
  parameter int                  SYNC_STAGES = 2,
  parameter int                  WAIT_EN     = 1,
  parameter int                  ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      A,
  inout  wire  [7:0]      cd,
  input  logic            rd_iorq_n,
  input  logic            wr_iorq_n,
  cpu_io_bridge_if.master io,
  output logic            wait_n,
  output logic            cs_n,
  output logic            timeout
);
  // state    | meaning
  // S_IDLE   | waiting for a synchronised strobe with a decoded hit
  // S_WAIT_ACK | read issued, stalling CPU until ack or timeout
  // S_HOLD   | access served (or illegal), waiting for both strobes high
  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_HOLD} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  logic                   any_hit;
  logic [2:0]             win_idx;
  logic [NUM_CH-1:0]      win_onehot;
  logic [7:0]             win_data;
  logic                   rd_hit;
  logic                   wr_hit;
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rd_s;
  logic                   wr_s;
  state_t                 state_q;
  logic [2:0]             ch_q;
  logic [7:0]             cnt_q;
  logic [7:0]             cnt_d;
  logic                   ack_sel;
  logic [7:0]             ack_data;
  logic [NUM_CH-1:0]      io_req_q;
  logic                   io_wr_q;
  logic [7:0]             io_addr_q;
  logic [7:0]             io_data_in_q;
  logic [7:0]             rd_data_q;
  logic                   timeout_q;
  logic [7:0]             cd_val;

  // Window decode; iterating downwards lets the lowest channel win overlaps.
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if ((A & CH_MASK[8*k +: 8]) == (CH_BASE[8*k +: 8] & CH_MASK[8*k +: 8])) begin
        any_hit = 1'b1;
        win_idx = 3'(k);
      end
    end
  end

  // One-hot of the winning channel and its read data for the unstalled path.
  always_comb begin
    win_onehot = '0;
    win_data   = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      win_onehot[k] = any_hit && (win_idx == 3'(k));
      if (win_idx == 3'(k)) win_data = io.io_data_out[8*k +: 8];
    end
  end

  // Ack and data of the channel owning the outstanding read; others ignored.
  always_comb begin
    ack_sel  = 1'b0;
    ack_data = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 3'(k)) begin
        ack_sel  = io.io_ack[k];
        ack_data = io.io_data_out[8*k +: 8];
      end
    end
  end

  // Saturating increment; the compare uses the incremented value so the
  // timeout fires after exactly ACK_TIMEOUT cycles spent in S_WAIT_ACK.
  always_comb begin
    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  assign rd_hit = any_hit & ~rd_iorq_n;
  assign wr_hit = any_hit & ~wr_iorq_n;
  assign cs_n   = ~(rd_hit | wr_hit);
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];

  // Strobe synchronisers. fill_q marks when the chains hold real samples after
  // reset, so a strobe already low at reset release is not seen as released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      fill_q    <= '0;
    end else begin
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_iorq_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_iorq_n};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Access sequencer: issue request, wait for ack/timeout, hold until release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HOLD;
      ch_q         <= '0;
      cnt_q        <= '0;
      io_req_q     <= '0;
      io_wr_q      <= 1'b0;
      io_addr_q    <= '0;
      io_data_in_q <= '0;
      rd_data_q    <= 8'hFF;
      timeout_q    <= 1'b0;
    end else begin
      io_req_q  <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rd_s && !wr_s) begin
            state_q <= S_HOLD;
          end else if ((rd_s != wr_s) && any_hit) begin
            io_addr_q    <= A;
            io_data_in_q <= cd;
            ch_q         <= win_idx;
            io_req_q     <= win_onehot;
            io_wr_q      <= ~wr_s;
            cnt_q        <= '0;
            state_q      <= (!rd_s && (WAIT_EN != 0)) ? S_WAIT_ACK : S_HOLD;
          end
        end
        S_WAIT_ACK: begin
          if (ack_sel) begin
            rd_data_q <= ack_data;
            state_q   <= S_HOLD;
          end else if (cnt_d == TIMEOUT_CNT) begin
            rd_data_q <= 8'hFF;
            timeout_q <= 1'b1;
            state_q   <= S_HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HOLD: begin
          if (rd_s && wr_s && fill_q[SYNC_STAGES-1]) state_q <= S_IDLE;
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign io.io_req     = io_req_q;
  assign io.io_wr      = io_wr_q;
  assign io.io_addr    = io_addr_q;
  assign io.io_data_in = io_data_in_q;
  assign timeout       = timeout_q;

  // wait_n follows the raw strobe so the CPU stalls before the sync completes.
  assign cd_val = (WAIT_EN != 0) ? rd_data_q : win_data;
  assign wait_n = (WAIT_EN != 0) ? ~(rd_hit && (state_q != S_HOLD)) : 1'b1;
  assign cd     = rd_hit ? cd_val : 8'hzz;
endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: directed vector table, hand sequences for illegal
// strobes and reset mid-access, and randomized accesses against a port-range model.
module tb_cpu_io_bridge;
  localparam int NCH = 2;
  localparam int TO  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] A = 8'h00;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       cd_oe = 1'b0;
  logic [7:0] cd_drv = 8'h00;
  tri1  [7:0] cd;
  logic       wait_n;
  logic       cs_n;
  logic       timeout;
  int         n_vec = 0;
  int         n_err = 0;

  assign cd = cd_oe ? cd_drv : 8'hzz;
  always #5 clk = ~clk;

  cpu_io_bridge_if #(.NUM_CH(NCH)) io_if ();

  cpu_io_bridge #(.ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .A         (A),
    .cd        (cd),
    .rd_iorq_n (rd_n),
    .wr_iorq_n (wr_n),
    .io        (io_if),
    .wait_n    (wait_n),
    .cs_n      (cs_n),
    .timeout   (timeout)
  );

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic [7:0] rdata;
    int         hold;
    logic [1:0] exp_req;
    logic [7:0] exp_cd;
    bit         exp_to;
    int         exp_wait_hi;
  } vec_t;

  // Observations of the last access
  int           o_nreq, o_req_cyc, o_nto, o_to_cyc, o_wait_hi, o_done;
  logic [NCH-1:0] o_req;
  logic         o_wr, o_wait0, o_cs0, o_cs_rel;
  logic [7:0]   o_addr, o_din, o_cd, o_cd_rel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected request for a port, from the documented port ranges.
  function automatic logic [1:0] model_req(input logic [7:0] a);
    if (a >= 8'h98 && a <= 8'h9B) return 2'b01;
    if (a >= 8'h30 && a <= 8'h33) return 2'b10;
    return 2'b00;
  endfunction

  // One CPU access; the peripheral acks `lat` cycles after it sees io_req.
  // Other channels get random ack noise throughout.
  task automatic run_access(input bit is_wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input int lat, input logic [7:0] rdata, input int hold);
    int ack_at;
    o_nreq = 0; o_nto = 0; o_req = '0; o_req_cyc = -1; o_to_cyc = -1;
    o_wait_hi = -1; o_cd = 8'h00; o_done = 0; ack_at = -1;
    o_wr = 1'b0; o_addr = 8'h00; o_din = 8'h00;
    tick();
    A = addr;
    if (is_wr) begin
      cd_oe = 1'b1; cd_drv = wdata; wr_n = 1'b0;
    end else begin
      rd_n = 1'b0;
    end
    #1;
    o_wait0 = wait_n;
    o_cs0   = cs_n;
    for (int c = 1; c <= 40 && o_done == 0; c++) begin
      tick();
      if (io_if.io_req != '0) begin
        o_nreq++;
        o_req = io_if.io_req; o_wr = io_if.io_wr;
        o_addr = io_if.io_addr; o_din = io_if.io_data_in;
        o_req_cyc = c;
        if (!is_wr) ack_at = c + lat;
      end
      if (timeout) begin
        o_nto++; o_to_cyc = c;
      end
      if (wait_n && o_wait_hi < 0) o_wait_hi = c;
      io_if.io_data_out = 16'($urandom);
      io_if.io_ack = 2'($urandom) & ~o_req;
      if (c == ack_at) begin
        io_if.io_ack = io_if.io_ack | o_req;
        for (int k = 0; k < NCH; k++)
          if (o_req[k]) io_if.io_data_out[8*k +: 8] = rdata;
      end
      if (c >= hold && wait_n) begin
        #1;
        o_cd = cd;
        o_done = 1;
      end
    end
    rd_n = 1'b1; wr_n = 1'b1; cd_oe = 1'b0; io_if.io_ack = '0;
    #1;
    o_cd_rel = cd;
    o_cs_rel = cs_n;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (io_if.io_req != '0) o_nreq++;
      if (timeout) o_nto++;
    end
  endtask

  task automatic check_access(input string nm, input bit is_wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [1:0] exp_req,
                              input logic [7:0] exp_cd, input bit exp_to, input int exp_wait_hi);
    bit hit;
    hit = (exp_req != 2'b00);
    chk({nm, ".done"}, o_done, 1);
    chk({nm, ".nreq"}, o_nreq, hit ? 1 : 0);
    chk({nm, ".cs_n"}, o_cs0, !hit);
    chk({nm, ".wait_n_edge"}, o_wait0, !(hit && !is_wr));
    chk({nm, ".ntimeout"}, o_nto, exp_to ? 1 : 0);
    chk({nm, ".cs_n_rel"}, o_cs_rel, 1);
    chk({nm, ".cd_rel_z"}, o_cd_rel, 8'hFF);
    if (hit) begin
      chk({nm, ".io_req"}, o_req, exp_req);
      chk({nm, ".req_cyc"}, o_req_cyc, 3);
      chk({nm, ".io_wr"}, o_wr, is_wr);
      chk({nm, ".io_addr"}, o_addr, addr);
      if (is_wr) begin
        chk({nm, ".io_data_in"}, o_din, wdata);
      end else begin
        chk({nm, ".cd"}, o_cd, exp_cd);
        chk({nm, ".wait_hi"}, o_wait_hi, exp_wait_hi);
        if (exp_to) chk({nm, ".to_cyc"}, o_to_cyc, 3 + TO);
      end
    end else if (!is_wr) begin
      chk({nm, ".cd_z"}, o_cd, 8'hFF);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int   n;
    int   wok;
    tbl[0]  = '{1'b1, 8'h99, 8'h5A, 99, 8'h00, 20, 2'b01, 8'h00, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h31, 8'h00, 5,  8'hC3, 6,  2'b10, 8'hC3, 1'b0, 9};
    tbl[2]  = '{1'b0, 8'h98, 8'h00, 99, 8'h00, 6,  2'b01, 8'hFF, 1'b1, 13};
    tbl[3]  = '{1'b0, 8'h40, 8'h00, 0,  8'h11, 6,  2'b00, 8'hFF, 1'b0, 0};
    tbl[4]  = '{1'b1, 8'h40, 8'h22, 0,  8'h00, 6,  2'b00, 8'h00, 1'b0, 0};
    tbl[5]  = '{1'b1, 8'h33, 8'hA7, 0,  8'h00, 6,  2'b10, 8'h00, 1'b0, 0};
    tbl[6]  = '{1'b0, 8'h34, 8'h00, 0,  8'h12, 6,  2'b00, 8'hFF, 1'b0, 0};
    tbl[7]  = '{1'b0, 8'h9B, 8'h00, 0,  8'h3C, 6,  2'b01, 8'h3C, 1'b0, 4};
    tbl[8]  = '{1'b0, 8'h30, 8'h00, 9,  8'hA5, 6,  2'b10, 8'hA5, 1'b0, 13};
    tbl[9]  = '{1'b0, 8'h99, 8'h00, 10, 8'h5E, 6,  2'b01, 8'hFF, 1'b1, 13};
    tbl[10] = '{1'b1, 8'h97, 8'h44, 0,  8'h00, 6,  2'b00, 8'h00, 1'b0, 0};
    tbl[11] = '{1'b0, 8'h2F, 8'h00, 0,  8'h66, 6,  2'b00, 8'hFF, 1'b0, 0};

    io_if.io_ack = '0;
    io_if.io_data_out = '0;

    // Reset values
    repeat (3) tick();
    chk("rst.io_req", io_if.io_req, 0);
    chk("rst.io_wr", io_if.io_wr, 0);
    chk("rst.io_addr", io_if.io_addr, 0);
    chk("rst.io_data_in", io_if.io_data_in, 0);
    chk("rst.timeout", timeout, 0);
    chk("rst.wait_n", wait_n, 1);
    chk("rst.cs_n", cs_n, 1);
    reset_n = 1'b1;
    repeat (6) tick();

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_access(tbl[i].is_wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].rdata, tbl[i].hold);
      check_access($sformatf("tbl%0d", i), tbl[i].is_wr, tbl[i].addr, tbl[i].wdata,
                   tbl[i].exp_req, tbl[i].exp_cd, tbl[i].exp_to, tbl[i].exp_wait_hi);
    end

    // Both strobes low: no request; stays held while either strobe is low
    tick();
    A = 8'h98; rd_n = 1'b0; wr_n = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (io_if.io_req != '0) n++;
    end
    chk("illegal.cs_n", cs_n, 0);
    wr_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (io_if.io_req != '0) n++;
    end
    chk("illegal.nreq", n, 0);
    chk("illegal.wait_n", wait_n, 1);
    rd_n = 1'b1;
    repeat (6) tick();
    run_access(1'b0, 8'h98, 8'h00, 2, 8'h77, 6);
    check_access("after_illegal", 1'b0, 8'h98, 8'h00, 2'b01, 8'h77, 1'b0, 6);

    // Reset pulsed mid-read with the strobe held low
    tick();
    A = 8'h31; rd_n = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst.io_req", io_if.io_req, 0);
    chk("midrst.io_addr", io_if.io_addr, 0);
    chk("midrst.wait_n", wait_n, 1);
    chk("midrst.cs_n", cs_n, 0);
    chk("midrst.cd", cd, 8'hFF);
    tick(); tick();
    reset_n = 1'b1;
    n = 0; wok = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (io_if.io_req != '0) n++;
      if (!wait_n) wok = 0;
    end
    chk("postrst.nreq", n, 0);
    chk("postrst.wait_n", wok, 1);
    rd_n = 1'b1;
    repeat (6) tick();
    run_access(1'b0, 8'h31, 8'h00, 3, 8'h5C, 6);
    check_access("after_rst", 1'b0, 8'h31, 8'h00, 2'b10, 8'h5C, 1'b0, 7);

    // Randomized accesses against the port-range model
    for (int i = 0; i < 40; i++) begin
      bit         w;
      logic [7:0] a, wd, rd;
      logic [1:0] er;
      int         lat;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a = 8'h98 + 8'($urandom_range(0, 3));
        1:       a = 8'h30 + 8'($urandom_range(0, 3));
        default: a = 8'($urandom);
      endcase
      wd  = 8'($urandom);
      rd  = 8'($urandom);
      lat = $urandom_range(0, 13);
      er  = model_req(a);
      run_access(w, a, wd, lat, rd, $urandom_range(4, 8));
      check_access($sformatf("rnd%0d", i), w, a, wd, er,
                   (lat < TO) ? rd : 8'hFF,
                   (!w && er != 2'b00 && lat >= TO),
                   (lat < TO) ? 4 + lat : 3 + TO);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_io_bridge.md
# cpu_io_bridge

Parametrised Z80 I/O-bus bridge between the asynchronous CPU port bus (A, cd, rd_iorq_n, wr_iorq_n) and NUM_CH internal peripherals (VDP, WS2812 driver, future blocks) running on clk. It synchronises the bus strobes and decodes each access against per-channel base/mask windows. It then issues exactly one single-cycle request per CPU access to the selected channel. Reads can stall the CPU through wait_n until the peripheral acknowledges, with a timeout fallback.

## Interface
- NUM_CH, 2: number of peripheral channels (1..8).
- CH_BASE, {8'h30, 8'h98}: packed NUM_CH×8 port bases; channel k uses bits [8k+7:8k].
- CH_MASK, {8'hFC, 8'hFC}: packed NUM_CH×8 address masks; 1 = bit compared.
- SYNC_STAGES, 2: flops in each strobe synchroniser (2..3).
- WAIT_EN, 1: 1 = reads stall via wait_n until io_ack; 0 = reads never stall.
- ACK_TIMEOUT, 255: clk cycles in WAIT_ACK before forced completion (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- A  in  8  CPU port address.
- cd  inout  8  CPU data bus.
- rd_iorq_n, wr_iorq_n  in  1 each  CPU I/O read/write strobes, asynchronous.
- io_req  out  NUM_CH  one-cycle request pulse, one bit per channel.
- io_wr  out  1  qualifies io_req: 1 = write.
- io_addr  out  8  latched port address of the current access.
- io_data_in  out  8  latched write data.
- io_data_out  in  NUM_CH×8  per-channel read data.
- io_ack  in  NUM_CH  read acknowledge; io_data_out[k] is valid when it is sampled.
- wait_n  out  1  CPU wait, active-low.
- cs_n  out  1  low while any channel is decoded with a strobe active.
- timeout  out  1  one-cycle pulse on read-ack timeout.

## Operation
- Decode, per channel: hit[k] = ((A & CH_MASK[k]) == (CH_BASE[k] & CH_MASK[k])). The lowest k wins when windows overlap.
- Raw decode is combinational: rd_hit = any hit & !rd_iorq_n. wr_hit is formed the same way with wr_iorq_n. cs_n = !(rd_hit | wr_hit).
- Synchronisation: rd_iorq_n and wr_iorq_n each pass through a SYNC_STAGES flop chain that resets to 1. A and cd are sampled only in the IDLE→REQ transition, when they are stable.
- FSM: IDLE, WAIT_ACK, HOLD. The request is issued in the transition out of IDLE.
  - IDLE: when exactly one synced strobe is low and a channel hits:
    - latch io_addr = A, io_data_in = cd, and ch = winning index;
    - pulse io_req[ch] for 1 cycle, with io_wr = 1 for a write;
    - a read with WAIT_EN=1 goes to WAIT_ACK; all other accesses go to HOLD.
  - IDLE, both synced strobes low: illegal; no request is issued, and the FSM goes to HOLD.
  - IDLE, strobe low with no hit: the FSM stays in IDLE.
  - WAIT_ACK: when io_ack[ch] = 1, set rd_data_r = io_data_out[ch] and go to HOLD. If the counter reaches ACK_TIMEOUT, set rd_data_r = 8'hFF, pulse timeout, and go to HOLD. io_ack on channels other than ch is ignored.
  - HOLD: when both synced strobes are high, go to IDLE. This guarantees one request per CPU access regardless of strobe length.
- Read data:
  - WAIT_EN=1: cd = rd_data_r while rd_hit, otherwise Z.
  - WAIT_EN=0: cd = io_data_out[winning hit] combinationally while rd_hit, otherwise Z.
- wait_n:
  - WAIT_EN=1: wait_n = !(rd_hit & state != HOLD). It is asserted combinationally from the strobe edge, so the CPU stalls before synchronisation completes.
  - WAIT_EN=0: wait_n is tied to 1.
- Reset behaviour:
  - Async reset puts the FSM in HOLD, so an access in flight at reset release produces no request.
  - Register reset values: io_req = 0, io_wr = 0, io_addr = 0, io_data_in = 0, timeout = 0, rd_data_r = 8'hFF, timeout counter = 0.
  - Resulting outputs during and after reset: wait_n = 1 (the FSM is in HOLD); cs_n and cd follow the bus combinationally.

## Timing
- Strobe falling edge to io_req pulse: SYNC_STAGES+1 clk cycles. With the default this is 3 cycles.
- io_req, io_wr, io_addr and io_data_in change together. io_addr and io_data_in stay stable until the next request.
- io_ack is sampled on the first rising edge where it is high in WAIT_ACK. It may be asserted in the same cycle as io_req is seen by the peripheral (earliest: the cycle after the io_req pulse). wait_n rises the cycle after the capture.
- Timeout counter: 8-bit, cleared on entry to WAIT_ACK, saturating; compared with == ACK_TIMEOUT.
- The minimum strobe-high gap between accesses is SYNC_STAGES+1 cycles. Shorter gaps merge two accesses into one; this is documented and not detected.

## Test plan
- Write 8'h5A to port 8'h99 -> io_req = 2'b01 for exactly 1 cycle, 3 cycles after the strobe edge; io_wr = 1, io_addr = 8'h99, io_data_in = 8'h5A; no second pulse during a 20-cycle strobe.
- Read port 8'h31, ch1 acks with 8'hC3 after 5 cycles -> wait_n low from the strobe edge until 1 cycle after the ack; cd = 8'hC3 while the strobe is low; cd = Z after release.
- Read port 8'h98 with no ack, ACK_TIMEOUT = 10 -> timeout pulse after 10 cycles in WAIT_ACK; cd = 8'hFF; wait_n released.
- Access to unmapped port 8'h40 -> no io_req, cs_n = 1, cd = Z, wait_n = 1.
- Both strobes low with port 8'h98 -> no io_req; FSM returns to IDLE only after both strobes are high.
- reset_n pulsed low mid-read with the strobe still low -> no io_req after release, wait_n = 1; the next full access is served normally.
